// File: rtl/game_pkg.sv
// Shared game-logic definitions: FSM encoding, LFSR geometry and spawn-field constants.
package game_pkg;

    localparam int unsigned LFSR_W   = 16;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned TYPE_W   = 2;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register: bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    localparam int unsigned X_ORIGIN = 64;
    localparam int unsigned Y_ORIGIN = 48;
    localparam int unsigned X_SPAN_W = 9;
    localparam int unsigned Y_SPAN_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_WAIT   = 2'd1;
    localparam state_t ST_ACTIVE = 2'd2;

    // X spans 64..575 and Y spans 48..303, both inside 10 bits
    function automatic logic [COORD_W-1:0] spawn_x(input logic [LFSR_W-1:0] v);
        return COORD_W'(X_ORIGIN) + COORD_W'(v[X_SPAN_W-1:0]);
    endfunction

    function automatic logic [COORD_W-1:0] spawn_y(input logic [LFSR_W-1:0] v);
        return COORD_W'(Y_ORIGIN) + COORD_W'(v[LFSR_W-1 -: Y_SPAN_W]);
    endfunction

endpackage

// File: rtl/powerup_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR, free-running whenever not in reset; shared with enemy spawn logic.
module lfsr16
    import game_pkg::*;
(
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            q <= seed;
        end else begin
            q <= {feedback, q[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/powerup_spawner.sv
// Periodically spawns a random powerup, keeps it on screen for a bounded time, and acknowledges pickups.
module powerup_spawner
    import game_pkg::*;
#(
    parameter int unsigned     SPAWN_INTERVAL = 600,
    parameter int unsigned     ONSCREEN_TIME  = 300,
    parameter logic [15:0]     LFSR_SEED      = 16'hACE1
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic               enable,
    input  logic               picked_up,
    output logic               generate_powerup,
    output logic [TYPE_W-1:0]  LFSR_powerup_type,
    output logic [COORD_W-1:0] powerup_x,
    output logic [COORD_W-1:0] powerup_y,
    output logic               powerup_visible,
    output logic               pickup_ack
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SPAWN_INTERVAL - 1);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(ONSCREEN_TIME - 1);

    logic [LFSR_W-1:0]  lfsr;
    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]   act_cnt, act_cnt_nxt;
    logic               gen_nxt, ack_nxt, vis_nxt;
    logic [TYPE_W-1:0]  type_nxt;
    logic [COORD_W-1:0] x_nxt, y_nxt;

    lfsr16 u_lfsr (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .seed      (LFSR_SEED),
        .q         (lfsr)
    );

    // Next-state and next-output logic; disable overrides everything and keeps the last spawn data
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        act_cnt_nxt  = act_cnt;
        gen_nxt      = 1'b0;
        ack_nxt      = 1'b0;
        vis_nxt      = powerup_visible;
        type_nxt     = LFSR_powerup_type;
        x_nxt        = powerup_x;
        y_nxt        = powerup_y;

        if (!enable) begin
            state_nxt    = ST_IDLE;
            wait_cnt_nxt = '0;
            act_cnt_nxt  = '0;
            vis_nxt      = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = '0;
                end
                ST_WAIT: begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt    = ST_ACTIVE;
                        wait_cnt_nxt = '0;
                        act_cnt_nxt  = '0;
                        gen_nxt      = 1'b1;
                        vis_nxt      = 1'b1;
                        type_nxt     = lfsr[TYPE_W-1:0];
                        x_nxt        = spawn_x(lfsr);
                        y_nxt        = spawn_y(lfsr);
                    end
                end
                ST_ACTIVE: begin
                    act_cnt_nxt = act_cnt + CNT_W'(1);
                    // A pickup on the timeout edge still counts as a pickup
                    if (picked_up) begin
                        ack_nxt      = 1'b1;
                        vis_nxt      = 1'b0;
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = '0;
                        act_cnt_nxt  = '0;
                    end else if (act_cnt == ACT_LAST) begin
                        vis_nxt      = 1'b0;
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = '0;
                        act_cnt_nxt  = '0;
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                    act_cnt_nxt  = '0;
                    vis_nxt      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state             <= ST_IDLE;
            wait_cnt          <= '0;
            act_cnt           <= '0;
            generate_powerup  <= 1'b0;
            pickup_ack        <= 1'b0;
            powerup_visible   <= 1'b0;
            LFSR_powerup_type <= '0;
            powerup_x         <= '0;
            powerup_y         <= '0;
        end else begin
            state             <= state_nxt;
            wait_cnt          <= wait_cnt_nxt;
            act_cnt           <= act_cnt_nxt;
            generate_powerup  <= gen_nxt;
            pickup_ack        <= ack_nxt;
            powerup_visible   <= vis_nxt;
            LFSR_powerup_type <= type_nxt;
            powerup_x         <= x_nxt;
            powerup_y         <= y_nxt;
        end
    end

endmodule

// File: tb/tb_powerup_spawner.sv
// Directed self-checking bench for powerup_spawner with a short interval and onscreen time.
module tb_powerup_spawner;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       enable = 1'b0;
    logic       picked_up = 1'b0;
    logic       generate_powerup;
    logic [1:0] LFSR_powerup_type;
    logic [9:0] powerup_x;
    logic [9:0] powerup_y;
    logic       powerup_visible;
    logic       pickup_ack;

    int checks = 0;
    int errors = 0;

    logic [15:0] m = 16'h0;
    logic [15:0] m_prev = 16'h0;
    logic [1:0]  exp_type = 2'd0;
    logic [9:0]  exp_x = 10'd0;
    logic [9:0]  exp_y = 10'd0;

    powerup_spawner #(
        .SPAWN_INTERVAL (4),
        .ONSCREEN_TIME  (3),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .frame_clk         (frame_clk),
        .Reset             (Reset),
        .enable            (enable),
        .picked_up         (picked_up),
        .generate_powerup  (generate_powerup),
        .LFSR_powerup_type (LFSR_powerup_type),
        .powerup_x         (powerup_x),
        .powerup_y         (powerup_y),
        .powerup_visible   (powerup_visible),
        .pickup_ack        (pickup_ack)
    );

    always #5 frame_clk = ~frame_clk;

    // Golden LFSR: x^16+x^14+x^13+x^11+1, shift right, feedback into bit 15
    always @(posedge frame_clk) begin
        m_prev <= m;
        if (Reset) m <= 16'hACE1;
        else       m <= {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]};
    end

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    // Steps until a spawn strobe, returning edges taken and acks seen; n stays -1 if it never comes
    task automatic wait_gen(output int n, output int acks);
        n = -1;
        acks = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (pickup_ack) acks++;
            if (generate_powerup) begin
                n = i;
                exp_type = m_prev[1:0];
                exp_x = 10'd64 + 10'(m_prev[8:0]);
                exp_y = 10'd48 + 10'(m_prev[15:8]);
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; enable = 1'b0; picked_up = 1'b0;
        step();
        step();
        checks++; if (generate_powerup !== 1'b0) begin errors++; $display("FAIL rst_gen got %b exp 0", generate_powerup); end
        checks++; if (pickup_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", pickup_ack); end
        checks++; if (powerup_visible !== 1'b0) begin errors++; $display("FAIL rst_vis got %b exp 0", powerup_visible); end
        checks++; if (LFSR_powerup_type !== 2'd0) begin errors++; $display("FAIL rst_type got %0d exp 0", LFSR_powerup_type); end
        checks++; if (powerup_x !== 10'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", powerup_x); end
        checks++; if (powerup_y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", powerup_y); end
        checks++; if (dut.u_lfsr.q !== 16'hACE1) begin errors++; $display("FAIL rst_lfsr got %h exp ace1", dut.u_lfsr.q); end
    endtask

    task automatic test_spawn_timeout();
        int n, acks;
        Reset = 1'b0; enable = 1'b1;
        step();
        checks++; if (dut.u_lfsr.q !== 16'h5670) begin errors++; $display("FAIL lfsr_first_shift got %h exp 5670", dut.u_lfsr.q); end
        checks++; if (generate_powerup !== 1'b0 || powerup_visible !== 1'b0) begin errors++; $display("FAIL wait_entry gen %b vis %b exp 0 0", generate_powerup, powerup_visible); end
        wait_gen(n, acks);
        checks++; if (n !== 4) begin errors++; $display("FAIL first_spawn_latency got %0d exp 4", n); end
        checks++; if (LFSR_powerup_type !== exp_type) begin errors++; $display("FAIL spawn_type got %0d exp %0d", LFSR_powerup_type, exp_type); end
        checks++; if (powerup_x !== exp_x) begin errors++; $display("FAIL spawn_x got %0d exp %0d", powerup_x, exp_x); end
        checks++; if (powerup_y !== exp_y) begin errors++; $display("FAIL spawn_y got %0d exp %0d", powerup_y, exp_y); end
        checks++; if (powerup_x < 10'd64 || powerup_x > 10'd575 || powerup_y < 10'd48 || powerup_y > 10'd303) begin errors++; $display("FAIL spawn_range got x %0d y %0d exp x 64..575 y 48..303", powerup_x, powerup_y); end
        checks++; if (powerup_visible !== 1'b1) begin errors++; $display("FAIL spawn_vis got %b exp 1", powerup_visible); end
        step();
        checks++; if (generate_powerup !== 1'b0 || powerup_visible !== 1'b1) begin errors++; $display("FAIL active1 gen %b vis %b exp 0 1", generate_powerup, powerup_visible); end
        step();
        checks++; if (powerup_visible !== 1'b1 || pickup_ack !== 1'b0) begin errors++; $display("FAIL active2 vis %b ack %b exp 1 0", powerup_visible, pickup_ack); end
        step();
        checks++; if (powerup_visible !== 1'b0 || pickup_ack !== 1'b0) begin errors++; $display("FAIL timeout vis %b ack %b exp 0 0", powerup_visible, pickup_ack); end
        wait_gen(n, acks);
        checks++; if (n !== 4 || acks !== 0) begin errors++; $display("FAIL respawn_after_timeout got n %0d acks %0d exp 4 0", n, acks); end
    endtask

    task automatic test_pickup_held();
        int n, acks;
        step();
        checks++; if (powerup_visible !== 1'b1) begin errors++; $display("FAIL pre_pickup_vis got %b exp 1", powerup_visible); end
        picked_up = 1'b1;
        step();
        checks++; if (pickup_ack !== 1'b1 || powerup_visible !== 1'b0) begin errors++; $display("FAIL pickup ack %b vis %b exp 1 0", pickup_ack, powerup_visible); end
        wait_gen(n, acks);
        checks++; if (n !== 4 || acks !== 0) begin errors++; $display("FAIL held_pickup_in_wait got n %0d acks %0d exp 4 0", n, acks); end
        picked_up = 1'b0;
    endtask

    task automatic test_pickup_on_timeout();
        int n, acks;
        step();
        step();
        checks++; if (powerup_visible !== 1'b1 || pickup_ack !== 1'b0) begin errors++; $display("FAIL pre_timeout vis %b ack %b exp 1 0", powerup_visible, pickup_ack); end
        picked_up = 1'b1;
        step();
        checks++; if (pickup_ack !== 1'b1 || powerup_visible !== 1'b0) begin errors++; $display("FAIL timeout_pickup ack %b vis %b exp 1 0", pickup_ack, powerup_visible); end
        picked_up = 1'b0;
        step();
        checks++; if (pickup_ack !== 1'b0) begin errors++; $display("FAIL ack_single got %b exp 0", pickup_ack); end
        wait_gen(n, acks);
        checks++; if (n !== 3 || acks !== 0) begin errors++; $display("FAIL respawn_after_pickup got n %0d acks %0d exp 3 0", n, acks); end
    endtask

    task automatic test_enable_drop();
        int n, acks, g;
        enable = 1'b0;
        step();
        checks++; if (powerup_visible !== 1'b0 || generate_powerup !== 1'b0 || pickup_ack !== 1'b0) begin errors++; $display("FAIL disable_active vis %b gen %b ack %b exp 0 0 0", powerup_visible, generate_powerup, pickup_ack); end
        checks++; if (powerup_x !== exp_x || powerup_y !== exp_y || LFSR_powerup_type !== exp_type) begin errors++; $display("FAIL disable_hold got x %0d y %0d t %0d exp %0d %0d %0d", powerup_x, powerup_y, LFSR_powerup_type, exp_x, exp_y, exp_type); end
        step();
        step();
        enable = 1'b1;
        wait_gen(n, acks);
        checks++; if (n !== 5) begin errors++; $display("FAIL reenable_from_active got %0d exp 5", n); end
        step();
        step();
        step();
        checks++; if (powerup_visible !== 1'b0) begin errors++; $display("FAIL timeout_before_wait_drop got %b exp 0", powerup_visible); end
        step();
        step();
        enable = 1'b0;
        g = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (generate_powerup) g++;
        end
        checks++; if (g !== 0 || powerup_visible !== 1'b0) begin errors++; $display("FAIL disable_wait strobes %0d vis %b exp 0 0", g, powerup_visible); end
        enable = 1'b1;
        wait_gen(n, acks);
        checks++; if (n !== 5) begin errors++; $display("FAIL reenable_from_wait got %0d exp 5", n); end
    endtask

    task automatic test_reset_active();
        int bad = 0;
        checks++; if (powerup_visible !== 1'b1) begin errors++; $display("FAIL pre_reset_vis got %b exp 1", powerup_visible); end
        Reset = 1'b1; picked_up = 1'b1;
        step();
        checks++; if ({generate_powerup, pickup_ack, powerup_visible} !== 3'b000) begin errors++; $display("FAIL reset_active flags got %b exp 000", {generate_powerup, pickup_ack, powerup_visible}); end
        checks++; if (LFSR_powerup_type !== 2'd0 || powerup_x !== 10'd0 || powerup_y !== 10'd0) begin errors++; $display("FAIL reset_active data got t %0d x %0d y %0d exp 0 0 0", LFSR_powerup_type, powerup_x, powerup_y); end
        checks++; if (dut.u_lfsr.q !== 16'hACE1) begin errors++; $display("FAIL reset_active_lfsr got %h exp ace1", dut.u_lfsr.q); end
        Reset = 1'b0; picked_up = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            checks++;
            if (dut.u_lfsr.q !== m || dut.u_lfsr.q == 16'h0) begin
                errors++;
                if (bad < 5) $display("FAIL lfsr_seq cycle %0d got %h exp %h", i, dut.u_lfsr.q, m);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_spawn_timeout();
        test_pickup_held();
        test_pickup_on_timeout();
        test_enable_drop();
        test_reset_active();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/powerup_spawner.md
POWERUP_SPAWNER -- requirements
Module: powerup_spawner

Interface
REQ-001 Parameter SPAWN_INTERVAL, default 600, frames spent in WAIT before each spawn (legal range 2..65535).
REQ-002 Parameter ONSCREEN_TIME, default 300, frames a spawned powerup stays visible (legal range 1..65535).
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-004 frame_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  game running; low forces IDLE.
REQ-007 picked_up  in  1  ship/powerup collision, level-sensitive, sampled each edge.
REQ-008 generate_powerup  out  1  one-cycle spawn strobe to power_up_select.
REQ-009 LFSR_powerup_type  out  2  powerup type; valid whenever generate_powerup=1, held until next spawn.
REQ-010 powerup_x  out  10  spawn X pixel; powerup_y  out  10  spawn Y pixel.
REQ-011 powerup_visible  out  1  powerup on screen and collectable.
REQ-012 pickup_ack  out  1  one-cycle pulse on accepted pickup.

Function
REQ-013 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, SHALL shift every cycle when not in reset, in every state including IDLE.
REQ-014 FSM states: IDLE, WAIT, ACTIVE; all outputs registered.
REQ-015 IDLE: enable=1 -> WAIT, wait_cnt<=0; otherwise stay.
REQ-016 WAIT: wait_cnt increments each cycle; on the edge where wait_cnt==SPAWN_INTERVAL-1: state<=ACTIVE, generate_powerup<=1, LFSR_powerup_type<=lfsr[1:0], powerup_x<=64+{1'b0,lfsr[8:0]}, powerup_y<=48+{2'b0,lfsr[15:8]}, powerup_visible<=1, act_cnt<=0.
REQ-017 Coordinate ranges SHALL be X 64..575, Y 48..303; the adds SHALL not overflow 10 bits.
REQ-018 generate_powerup SHALL be high exactly one cycle per spawn, N=SPAWN_INTERVAL cycles after WAIT entry.
REQ-019 ACTIVE: act_cnt increments each cycle; picked_up=1 -> pickup_ack<=1, powerup_visible<=0, state<=WAIT, wait_cnt<=0.
REQ-020 ACTIVE: act_cnt==ONSCREEN_TIME-1 with picked_up=0 -> timeout: powerup_visible<=0, state<=WAIT, wait_cnt<=0, no pickup_ack.
REQ-021 Pickup and timeout in the same cycle SHALL be treated as pickup.
REQ-022 picked_up SHALL be ignored in IDLE and WAIT; a held-high picked_up produces at most one pickup_ack per spawn.
REQ-023 enable=0 in any state -> IDLE next edge, powerup_visible<=0, counters cleared, no strobe or ack issued; LFSR_powerup_type, powerup_x, powerup_y hold.
REQ-024 Counters are 16-bit; wait_cnt/act_cnt SHALL never wrap (cleared on every state exit).

Reset
REQ-025 Reset=1 at an edge: state<=IDLE, lfsr<=LFSR_SEED, wait_cnt<=0, act_cnt<=0, generate_powerup, pickup_ack, powerup_visible<=0, LFSR_powerup_type<=0, powerup_x<=0, powerup_y<=0.
REQ-026 Reset SHALL override enable and picked_up; reset mid-ACTIVE removes the powerup without ack or strobe.

Structure
REQ-027 Shared package game_pkg SHALL hold the FSM state enum, LFSR width, polynomial tap constants, and the spawn-field origin/range constants (64, 48, 9-bit X span, 8-bit Y span).
REQ-028 The LFSR SHALL be a sub-module lfsr16 (ports frame_clk, Reset, seed, q[15:0]), reusable by enemy spawn logic.

Verification (SPAWN_INTERVAL=4, ONSCREEN_TIME=3, seed 16'hACE1)
REQ-029 Reset, enable=1 -> WAIT after 1 edge; generate_powerup high exactly one cycle, 4 cycles after WAIT entry; LFSR_powerup_type == lfsr[1:0] of that edge; X in 64..575, Y in 48..303.
REQ-030 No pickup after spawn -> powerup_visible high 3 cycles then 0, pickup_ack never asserts, next strobe 4 cycles later.
REQ-031 picked_up=1 in second ACTIVE cycle and held 10 cycles -> single pickup_ack pulse, visible drops next edge, next strobe 4 cycles after WAIT re-entry.
REQ-032 picked_up=1 on third ACTIVE cycle (timeout edge) -> pickup_ack=1, treated as pickup.
REQ-033 enable dropped mid-WAIT and mid-ACTIVE -> IDLE, visible=0, no strobe; re-enable restarts full 4-cycle interval.
REQ-034 Reset asserted mid-ACTIVE -> all outputs 0 next edge; LFSR sequence restarts from 16'hACE1, matching golden 16-bit model over 1000 cycles, never reaching 0.
